fibgen_param: RTL
=================

Name: fibgen_param

Overview:
Parametrised successor to the fixed 2-in/4-out BCD Fibonacci generator. Accepts an IN_DIGITS-digit BCD index n and returns fib(n) as OUT_DIGITS BCD digits, where fib(0)=0 and fib(1)=1.
- Internal flow: sequential BCD->binary conversion, iterative Fibonacci, then shift-add-3 binary->BCD conversion.
- Adds saturating overflow, invalid-digit error reporting and an optional binary result port.
- Sits behind the board's BCD switch/7-seg front end as a start/ready/done slave.

Parameters:
IN_DIGITS, 2, number of BCD index digits; legal range 1..3.
OUT_DIGITS, 4, number of BCD result digits; legal range 1..9.
Derived localparams, not overridable:
- LIMIT = 10^OUT_DIGITS - 1.
- BIN_W = clog2(2*LIMIT+1).
- CNT_W = clog2(10^IN_DIGITS).

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  synchronous active-low reset.
i_start  in  1  start request; sampled only while o_ready=1.
i_gen_amt_bcd  in  4*IN_DIGITS  index n, packed BCD, most-significant digit in the top nibble.
o_final_bcd  out  4*OUT_DIGITS  result, packed BCD, most-significant digit in the top nibble.
o_ready  out  1  high in IDLE.
o_done  out  1  one-cycle pulse when the result is valid.
o_overflow  out  1  fib(n) > LIMIT; result is saturated.
o_err  out  1  an index digit was > 9.

Behaviour:
- Reset (i_rst_n=0 at a rising edge), from any state including mid-operation:
  - state <= IDLE.
  - o_ready=1; o_done=0; o_overflow=0; o_err=0; o_final_bcd=0.
  - All internal registers cleared.
- IDLE:
  - o_ready=1.
  - i_start=1 at an edge: latch i_gen_amt_bcd, clear o_overflow and o_err, go to CONV.
  - o_final_bcd keeps the previous result until DONE.
- CONV (IN_DIGITS cycles):
  - Each cycle, MSD first: acc <= acc*10 + digit.
  - Any latched digit > 9, checked in the first CONV cycle: set o_err, result = 0, go to DONE.
- FIB:
  - Entry values: a=0, b=1, cnt=acc.
  - Each cycle with cnt != 0: a <= b; b <= a+b; cnt <= cnt-1.
  - If b > LIMIT when cnt != 0: o_overflow=1, result = LIMIT (all BCD 9s), skip to DONE.
  - cnt == 0: result = a, go to B2B.
  - FIB occupies n+1 cycles when there is no overflow.
- B2B (BIN_W cycles): shift-add-3 (double dabble), one bit per cycle.
- DONE (1 cycle):
  - Drive o_final_bcd; o_done=1; o_ready=0.
  - Next state IDLE.
- Latency, no error or overflow: o_done is high on cycle 1 + IN_DIGITS + (n+1) + BIN_W after the sampling edge.
- i_start while not in IDLE: ignored, with no queuing.
- i_start held high through DONE: a new run starts on the first IDLE edge.
- o_ready and o_done are never high together.
- No wrap-around: b <= 2*LIMIT by construction, and BIN_W covers that bound.
- Error and overflow are exclusive; err takes priority.

Optional Feature:
Macro FIBGEN_BIN_OUT_EN.
- Defined: adds port o_final_bin (out, BIN_W) carrying the binary result, valid with o_done.
  - The B2B state is still used, so latency is unchanged.
  - o_final_bin is LIMIT on overflow and 0 on err.
  - Reset value 0.
- Undefined: port and register are absent; behaviour is otherwise identical.

Test Plan:
1. Defaults; reset, then start with n=0x10 -> o_final_bcd=0x0055, o_overflow=0, o_done pulses exactly 1 cycle, at latency 1+2+11+15=29.
2. Defaults; n=0x00 -> 0x0000; n=0x01 -> 0x0001; n=0x20 -> 0x6765, o_overflow=0.
3. Defaults; n=0x21 -> o_final_bcd=0x9999, o_overflow=1; n=0x99 -> same; the next start with n=0x05 -> 0x0005, o_overflow=0.
4. Defaults; n=0x1A -> o_err=1, o_final_bcd=0x0000, o_done pulse; i_start pulsed mid-run in another run -> ignored, single o_done.
5. Defaults; start n=0x20, assert i_rst_n=0 during FIB -> next cycle o_ready=1, all outputs 0, no o_done; the restart completes normally.
6. IN_DIGITS=2, OUT_DIGITS=6 with FIBGEN_BIN_OUT_EN -> n=0x30 gives o_final_bcd=0x832040 and o_final_bin=832040; n=0x31 gives 0x999999, o_overflow=1.

Source files
------------

// File: rtl/fibgen_param.sv
// BCD-indexed Fibonacci generator: BCD->bin, iterate, double-dabble back.
// FIBGEN_BIN_OUT_EN adds o_final_bin carrying the binary result.
module fibgen_param #(
  parameter int IN_DIGITS = 2,
  parameter int OUT_DIGITS = 4,
  localparam int LIMIT = 10**OUT_DIGITS - 1,
  localparam int BIN_W = $clog2(2*LIMIT + 1),
  localparam int CNT_W = $clog2(10**IN_DIGITS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [4*IN_DIGITS-1:0]  i_gen_amt_bcd,
  output logic [4*OUT_DIGITS-1:0] o_final_bcd,
  output logic                    o_ready,
  output logic                    o_done,
  output logic                    o_overflow,
`ifdef FIBGEN_BIN_OUT_EN
  output logic                    o_err,
  output logic [BIN_W-1:0]        o_final_bin
`else
  output logic                    o_err
`endif
);

  localparam int STEP_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] LIM_B = BIN_W'(LIMIT);
  localparam logic [STEP_W-1:0] CONV_END = STEP_W'(IN_DIGITS - 1);
  localparam logic [STEP_W-1:0] B2B_END = STEP_W'(BIN_W - 1);

  typedef enum logic [2:0] {
    IDLE, CONV, FIB, B2B, DONE
  } state_t;

  state_t state, state_nx;

  logic [4*IN_DIGITS-1:0]  idx_q;
  logic [CNT_W-1:0]        acc;
  logic [STEP_W-1:0]       step;
  logic [BIN_W-1:0]        a, b, bin_q;
  logic [4*OUT_DIGITS-1:0] bcd_q;

  logic [3:0]              digit;
  logic [CNT_W-1:0]        acc_nx;
  logic                    bad, bad_first, conv_last;
  logic                    cnt_zero, b_big, b2b_last;
  logic [4*OUT_DIGITS-1:0] adj, bcd_nx;

  assign digit     = idx_q[4*IN_DIGITS-1 -: 4];
  assign acc_nx    = (acc << 3) + (acc << 1) + CNT_W'(digit);
  assign bad_first = (step == '0) && bad;
  assign conv_last = (step == CONV_END);
  assign cnt_zero  = (acc == '0);
  assign b_big     = (b > LIM_B);
  assign b2b_last  = (step == B2B_END);
  assign o_ready   = (state == IDLE);
  assign o_done    = (state == DONE);

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < IN_DIGITS; i++)
      if (idx_q[4*i +: 4] > 4'd9) bad = 1'b1;
  end

  // One double-dabble step: add-3 on digits >= 5, then shift in next bit
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < OUT_DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    bcd_nx = {adj[4*OUT_DIGITS-2:0], bin_q[BIN_W-1]};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (i_start) state_nx = CONV;
      CONV: begin
        if (bad_first)      state_nx = DONE;
        else if (conv_last) state_nx = FIB;
      end
      FIB: begin
        if (cnt_zero)   state_nx = B2B;
        else if (b_big) state_nx = DONE;
      end
      B2B:  if (b2b_last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      idx_q       <= '0;
      acc         <= '0;
      step        <= '0;
      a           <= '0;
      b           <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      o_final_bcd <= '0;
      o_overflow  <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (i_start) begin
          idx_q      <= i_gen_amt_bcd;
          acc        <= '0;
          step       <= '0;
          o_overflow <= 1'b0;
          o_err      <= 1'b0;
        end
        CONV: begin
          if (bad_first) begin
            o_err       <= 1'b1;
            o_final_bcd <= '0;
          end else begin
            acc   <= acc_nx;
            idx_q <= idx_q << 4;
            if (conv_last) begin
              step <= '0;
              a    <= '0;
              b    <= BIN_W'(1);
            end else begin
              step <= step + STEP_W'(1);
            end
          end
        end
        FIB: begin
          if (cnt_zero) begin
            bin_q <= a;
            bcd_q <= '0;
            step  <= '0;
          end else if (b_big) begin
            o_overflow  <= 1'b1;
            o_final_bcd <= {OUT_DIGITS{4'h9}};
          end else begin
            a   <= b;
            b   <= a + b;
            acc <= acc - CNT_W'(1);
          end
        end
        B2B: begin
          bin_q <= bin_q << 1;
          bcd_q <= bcd_nx;
          step  <= step + STEP_W'(1);
          if (b2b_last) o_final_bcd <= bcd_nx;
        end
        default: ;
      endcase
    end
  end

`ifdef FIBGEN_BIN_OUT_EN
  // a is untouched during B2B, so it still holds the binary result
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      o_final_bin <= '0;
    else if (state == CONV && bad_first)
      o_final_bin <= '0;
    else if (state == FIB && !cnt_zero && b_big)
      o_final_bin <= LIM_B;
    else if (state == B2B && b2b_last)
      o_final_bin <= a;
  end
`endif

endmodule
